// File: rtl/pwm_capture_pkg.sv
// rtl/pwm_capture_pkg.sv - shared register map and channel state encodings for pwm_capture
package pwm_capture_pkg;

  localparam logic [7:0] CH_STRIDE    = 8'h0C;
  localparam logic [7:0] OFF_CTRL     = 8'h00;
  localparam logic [7:0] OFF_HIGH     = 8'h04;
  localparam logic [7:0] OFF_PERIOD   = 8'h08;
  localparam logic [7:0] ADDR_STATUS  = 8'h60;
  localparam logic [7:0] ADDR_TIMEOUT = 8'h64;

  typedef enum logic [1:0] {
    ST_DIS = 2'd0,
    ST_ARM = 2'd1,
    ST_HI  = 2'd2,
    ST_LO  = 2'd3
  } ch_state_t;

  function automatic logic [7:0] ch_base(input int n);
    return 8'(n) * CH_STRIDE;
  endfunction

endpackage

// File: rtl/pwm_capture_ch.sv
// rtl/pwm_capture_ch.sv - one capture channel: synchroniser, edge detect, measurement FSM
module pwm_capture_ch
  import pwm_capture_pkg::*;
#(
  parameter int SYNC = 2
) (
  input  logic        clk,
  input  logic        res,
  input  logic        enable,
  input  logic [31:0] timeout,
  input  logic        cap_async,
  output logic [31:0] high,
  output logic [31:0] period,
  output logic        valid_set,
  output logic        ovf_set
);

  logic [SYNC-1:0] sync_q;
  logic            prev_q;
  logic            rise;
  logic            fall;

  ch_state_t   state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] hcnt_q, hcnt_d;
  logic [31:0] high_d, period_d;
  logic [31:0] cnt_inc;
  logic        timed_out;

  always_ff @(posedge clk) begin
    if (res) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC-2:0], cap_async};
      prev_q <= sync_q[SYNC-1];
    end
  end

  assign rise = sync_q[SYNC-1] & ~prev_q;
  assign fall = ~sync_q[SYNC-1] & prev_q;

  // Counter saturates rather than wrapping when no timeout is programmed.
  assign cnt_inc   = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;
  assign timed_out = (timeout != 32'd0) && (cnt_q == timeout);

  always_ff @(posedge clk) begin
    if (res) begin
      state_q <= ST_DIS;
      cnt_q   <= '0;
      hcnt_q  <= '0;
      high    <= '0;
      period  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hcnt_q  <= hcnt_d;
      high    <= high_d;
      period  <= period_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hcnt_d    = hcnt_q;
    high_d    = high;
    period_d  = period;
    valid_set = 1'b0;
    ovf_set   = 1'b0;
    if (!enable) begin
      state_d = ST_DIS;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_DIS: begin
          state_d = ST_ARM;
          cnt_d   = '0;
        end
        ST_ARM: begin
          if (rise) begin
            cnt_d   = 32'd1;
            state_d = ST_HI;
          end
        end
        ST_HI: begin
          if (timed_out) begin
            ovf_set = 1'b1;
            cnt_d   = '0;
            state_d = ST_ARM;
          end else begin
            cnt_d = cnt_inc;
            if (fall) begin
              hcnt_d  = cnt_q;
              state_d = ST_LO;
            end
          end
        end
        ST_LO: begin
          if (timed_out) begin
            ovf_set = 1'b1;
            cnt_d   = '0;
            state_d = ST_ARM;
          end else if (rise) begin
            // HIGH and PERIOD land together so software never sees a torn pair.
            high_d    = hcnt_q;
            period_d  = cnt_q;
            valid_set = 1'b1;
            cnt_d     = 32'd1;
            state_d   = ST_HI;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = ST_DIS;
          cnt_d   = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - eight-channel pulse high-time/period capture with register bus and irq
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int NCH  = 8,
  parameter int SYNC = 2
) (
  input  logic           clk,
  input  logic           res,
  input  logic           rd,
  input  logic           wr,
  input  logic [31:0]    addr,
  input  logic [31:0]    data_in,
  input  logic [NCH-1:0] cap_in,
  output logic [31:0]    data_out,
  output logic           irq
);

  logic [7:0]     a8;
  logic [NCH-1:0] en_q;
  logic [NCH-1:0] irq_en_q;
  logic [NCH-1:0] valid_q;
  logic [NCH-1:0] ovf_q;
  logic [31:0]    timeout_q;

  logic [NCH-1:0] valid_set_w;
  logic [NCH-1:0] ovf_set_w;
  logic [31:0]    high_w   [NCH];
  logic [31:0]    period_w [NCH];

  logic           wr_status;
  logic [NCH-1:0] valid_clr;
  logic [NCH-1:0] ovf_clr;
  logic [31:0]    rd_data;
  logic           unused_addr;

  assign a8          = addr[7:0];
  assign unused_addr = ^addr[31:8];

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    pwm_capture_ch #(.SYNC(SYNC)) u_ch (
      .clk       (clk),
      .res       (res),
      .enable    (en_q[g]),
      .timeout   (timeout_q),
      .cap_async (cap_in[g]),
      .high      (high_w[g]),
      .period    (period_w[g]),
      .valid_set (valid_set_w[g]),
      .ovf_set   (ovf_set_w[g])
    );
  end

  assign wr_status = wr && (a8 == ADDR_STATUS);
  assign valid_clr = wr_status ? data_in[NCH-1:0]  : '0;
  assign ovf_clr   = wr_status ? data_in[8 +: NCH] : '0;

  always_ff @(posedge clk) begin
    if (res) begin
      en_q      <= '0;
      irq_en_q  <= '0;
      valid_q   <= '0;
      ovf_q     <= '0;
      timeout_q <= '0;
      data_out  <= '0;
    end else begin
      // A capture event in the same cycle as its W1C wins: set is OR-ed in last.
      valid_q <= (valid_q & ~valid_clr) | valid_set_w;
      ovf_q   <= (ovf_q & ~ovf_clr) | ovf_set_w;
      if (wr) begin
        if (a8 == ADDR_TIMEOUT) timeout_q <= data_in;
        for (int n = 0; n < NCH; n++) begin
          if (a8 == ch_base(n) + OFF_CTRL) begin
            en_q[n]     <= data_in[0];
            irq_en_q[n] <= data_in[1];
          end
        end
      end else if (rd) begin
        data_out <= rd_data;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    if (a8 == ADDR_STATUS) begin
      rd_data[NCH-1:0]  = valid_q;
      rd_data[8 +: NCH] = ovf_q;
    end else if (a8 == ADDR_TIMEOUT) begin
      rd_data = timeout_q;
    end
    for (int n = 0; n < NCH; n++) begin
      if (a8 == ch_base(n) + OFF_CTRL)   rd_data = {30'b0, irq_en_q[n], en_q[n]};
      if (a8 == ch_base(n) + OFF_HIGH)   rd_data = high_w[n];
      if (a8 == ch_base(n) + OFF_PERIOD) rd_data = period_w[n];
    end
  end

  assign irq = |((valid_q | ovf_q) & irq_en_q);

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - directed self-checking bench for pwm_capture
module tb_pwm_capture;

  logic        clk = 1'b0;
  logic        res = 1'b1;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] data_in = '0;
  logic [7:0]  cap_in = '0;
  logic [31:0] data_out;
  logic        irq;

  int n_vec = 0;
  int n_bad = 0;

  logic [31:0] exp_q [$];
  string       tag_q [$];
  logic [31:0] last_exp = '0;

  logic [7:0] gen_on = '0;
  logic [7:0] man = '0;
  int hi_len [8];
  int per_len [8];
  int phase [8];

  pwm_capture #(.NCH(8), .SYNC(2)) dut (
    .clk      (clk),
    .res      (res),
    .rd       (rd),
    .wr       (wr),
    .addr     (addr),
    .data_in  (data_in),
    .cap_in   (cap_in),
    .data_out (data_out),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  // Pulse source: updates just after each falling edge so stimulus set on that edge is seen.
  always @(negedge clk) begin
    #1;
    for (int n = 0; n < 8; n++) begin
      if (gen_on[n]) begin
        cap_in[n] = (phase[n] < hi_len[n]);
        phase[n]  = (phase[n] + 1 >= per_len[n]) ? 0 : phase[n] + 1;
      end else begin
        cap_in[n] = man[n];
        phase[n]  = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = {24'h0, a}; data_in = d; wr = 1'b1;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, input logic [31:0] exp, input string tag);
    @(negedge clk);
    addr = {24'h0, a}; rd = 1'b1;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(negedge clk);
    rd = 1'b0;
    check(tag_q.pop_front(), data_out, exp_q.pop_front());
    last_exp = exp;
  endtask

  // wr and rd together: the write happens and data_out keeps its previous value.
  task automatic bus_wr_rd(input logic [7:0] a, input logic [31:0] d, input string tag);
    @(negedge clk);
    addr = {24'h0, a}; data_in = d; wr = 1'b1; rd = 1'b1;
    exp_q.push_back(last_exp);
    tag_q.push_back(tag);
    @(negedge clk);
    wr = 1'b0; rd = 1'b0;
    check(tag_q.pop_front(), data_out, exp_q.pop_front());
  endtask

  initial begin
    for (int n = 0; n < 8; n++) begin
      hi_len[n]  = 10 + 5 * n;
      per_len[n] = 50 + 13 * n;
      phase[n]   = 0;
    end
    wait_cycles(3);
    res = 1'b0;

    // Reset state and full map readback
    check("reset_data_out", data_out, 32'h0);
    check("reset_irq", {31'b0, irq}, 32'h0);
    for (int n = 0; n < 8; n++) begin
      bus_read(8'(n * 12),     32'h0, $sformatf("reset_ctrl%0d", n));
      bus_read(8'(n * 12 + 4), 32'h0, $sformatf("reset_high%0d", n));
      bus_read(8'(n * 12 + 8), 32'h0, $sformatf("reset_period%0d", n));
    end
    bus_read(8'h60, 32'h0, "reset_status");
    bus_read(8'h64, 32'h0, "reset_timeout");
    bus_write(8'h04, 32'h1234);
    bus_read(8'h04, 32'h0, "ro_write_ignored");
    bus_read(8'h61, 32'h0, "unaligned_unmapped");
    bus_read(8'h68, 32'h0, "unmapped");

    // ch0 30/100 pulse train
    bus_write(8'h00, 32'h1);
    hi_len[0] = 30; per_len[0] = 100; gen_on[0] = 1'b1;
    wait_cycles(60);
    bus_read(8'h60, 32'h0, "ch0_no_valid_before_2nd_rise");
    wait_cycles(300);
    gen_on[0] = 1'b0;
    bus_read(8'h00, 32'h1, "ch0_ctrl");
    bus_read(8'h04, 32'd30, "ch0_high");
    bus_read(8'h08, 32'd100, "ch0_period");
    bus_read(8'h60, 32'h1, "ch0_status");
    bus_read(8'h10, 32'h0, "ch1_high_untouched");
    bus_read(8'h14, 32'h0, "ch1_period_untouched");
    bus_write(8'h00, 32'h0);

    // Timeout on ch3
    bus_write(8'h64, 32'd500);
    bus_write(8'h24, 32'h3);
    man[3] = 1'b1;
    wait_cycles(10);
    man[3] = 1'b0;
    wait_cycles(100);
    check("irq_before_timeout", {31'b0, irq}, 32'h0);
    wait_cycles(500);
    check("irq_after_timeout", {31'b0, irq}, 32'h1);
    bus_read(8'h60, 32'h801, "status_ovf3");
    bus_read(8'h1C, 32'h0, "ch2_high_untouched");
    bus_read(8'h28, 32'h0, "ch3_high_not_updated");
    bus_write(8'h60, 32'h800);
    check("irq_after_w1c", {31'b0, irq}, 32'h0);
    bus_read(8'h60, 32'h1, "status_after_w1c");
    bus_read(8'h64, 32'd500, "timeout_rb");
    bus_write(8'h64, 32'h0);

    // W1C collides with a fresh ch0 capture
    bus_write(8'h00, 32'h1);
    wait_cycles(5);
    man[0] = 1'b1;
    wait_cycles(20);
    man[0] = 1'b0;
    wait_cycles(30);
    man[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    addr = 32'h60; data_in = 32'h1; wr = 1'b1;
    @(negedge clk);
    wr = 1'b0;
    bus_read(8'h60, 32'h1, "w1c_vs_capture_set_wins");
    bus_read(8'h04, 32'd20, "ch0_high_manual");
    bus_read(8'h08, 32'd50, "ch0_period_manual");
    bus_write(8'h60, 32'h1);
    bus_read(8'h60, 32'h0, "plain_w1c_clears");

    // ch2 disabled mid-HI then re-enabled
    bus_write(8'h18, 32'h1);
    hi_len[2] = 40; per_len[2] = 90; gen_on[2] = 1'b1;
    wait_cycles(300);
    bus_read(8'h1C, 32'd40, "ch2_high");
    bus_read(8'h20, 32'd90, "ch2_period");
    begin
      int i;
      for (i = 0; i < 200 && phase[2] != 10; i++) @(negedge clk);
      check("ch2_phase_reached", {31'b0, (i < 200)}, 32'h1);
    end
    bus_write(8'h18, 32'h0);
    man[2] = 1'b1; gen_on[2] = 1'b0;
    bus_write(8'h60, 32'h4);
    bus_read(8'h60, 32'h0, "status_cleared_while_dis");
    wait_cycles(5);
    bus_write(8'h18, 32'h1);
    wait_cycles(5);
    man[2] = 1'b0;
    wait_cycles(15);
    man[2] = 1'b1;
    wait_cycles(25);
    man[2] = 1'b0;
    bus_read(8'h1C, 32'd40, "ch2_high_retained");
    bus_read(8'h60, 32'h0, "no_one_edge_artefact");
    wait_cycles(31);
    man[2] = 1'b1;
    wait_cycles(5);
    bus_read(8'h1C, 32'd25, "ch2_high_after_rearm");
    bus_read(8'h20, 32'd60, "ch2_period_after_rearm");
    bus_read(8'h60, 32'h4, "ch2_valid_after_rearm");

    // Loopback on all channels
    bus_wr_rd(8'h3C, 32'h1, "wr_rd_same_cycle_holds");
    bus_read(8'h3C, 32'h1, "wr_rd_write_done");
    for (int n = 0; n < 8; n++) begin
      if (n != 3 && n != 5) bus_write(8'(n * 12), 32'h1);
      hi_len[n]  = 10 + 5 * n;
      per_len[n] = 50 + 13 * n;
    end
    gen_on = 8'hFF;
    wait_cycles(500);
    for (int n = 0; n < 8; n++) begin
      bus_read(8'(n * 12 + 4), 32'(hi_len[n]),  $sformatf("loop_high%0d", n));
      bus_read(8'(n * 12 + 8), 32'(per_len[n]), $sformatf("loop_period%0d", n));
    end
    bus_read(8'h60, 32'hFF, "loop_status");
    check("loop_irq", {31'b0, irq}, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
